id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 141 ++++++++++++++
 tb/tb_id_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: one-entry pipeline register, 32x32 register file with writeback
// bypass, immediate generation, load-use interlock and branch/jump resolution.
module id_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fs_to_ds_valid,
    input  logic [63:0]  if_id_bus_in,
    output logic         ds_allowin,
    input  logic         es_allowin,
    output logic         ds_to_es_valid,
    output logic [144:0] id_ex_bus_out,
    input  logic         wb_we,
    input  logic [4:0]   wb_waddr,
    input  logic [31:0]  wb_wdata,
    input  logic         es_load_valid,
    input  logic [4:0]   es_load_rd,
    output logic         br_taken,
    output logic [31:0]  br_target
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic               ds_valid_q, ds_valid_d;
    logic [63:0]        ds_bus_q, ds_bus_d;
    logic [31:0]        rf_q [32];
    logic [31:0]        inst, pc;
    logic [6:0]         opcode;
    logic [4:0]         rd, rs1, rs2;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [31:0]        imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0]        rs1_data, rs2_data;
    logic signed [31:0] rs1_s, rs2_s;
    logic               uses_rs1, uses_rs2, rf_we;
    logic               load_use, ds_ready_go, is_jump, br_cond;

    assign inst     = ds_bus_q[63:32];
    assign pc       = ds_bus_q[31:0];
    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct7b5 = inst[30];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        rf_we    = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin imm = imm_i; uses_rs1 = 1'b1; rf_we = 1'b1; end
            OP_STORE:                 begin imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH:                begin imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI, OP_AUIPC:         begin imm = imm_u; rf_we = 1'b1; end
            OP_JAL:                   begin imm = imm_j; rf_we = 1'b1; end
            OP_REG:                   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; rf_we = 1'b1; end
            default:                  ;
        endcase
        if (rd == 5'd0) rf_we = 1'b0;
    end

    // Same-cycle writeback wins over the stored value; x0 is never bypassed.
    always_comb begin
        rs1_data = rf_q[rs1];
        rs2_data = rf_q[rs2];
        if (wb_we && wb_waddr != 5'd0 && wb_waddr == rs1) rs1_data = wb_wdata;
        if (wb_we && wb_waddr != 5'd0 && wb_waddr == rs2) rs2_data = wb_wdata;
    end

    assign load_use = es_load_valid && es_load_rd != 5'd0 &&
                      ((uses_rs1 && es_load_rd == rs1) || (uses_rs2 && es_load_rd == rs2));
    assign ds_ready_go    = !(ds_valid_q && load_use);
    assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go;

    assign rs1_s = $signed(rs1_data);
    assign rs2_s = $signed(rs2_data);

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = (rs1_s < rs2_s);
            3'b101:  br_cond = (rs1_s >= rs2_s);
            3'b110:  br_cond = (rs1_data < rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign br_taken  = ds_to_es_valid && es_allowin &&
                       (is_jump || (opcode == OP_BRANCH && br_cond));
    assign br_target = (opcode == OP_JALR) ? ((rs1_data + imm_i) & ~32'd1)
                                           : (pc + ((opcode == OP_JAL) ? imm_j : imm_b));

    assign id_ex_bus_out = {rf_we, funct7b5, funct3, opcode, rd, imm, rs2_data, rs1_data, pc};

    // The fetch slot arriving alongside a taken redirect is the wrong path: drop it.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_bus_d   = ds_bus_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid && !br_taken;
            if (fs_to_ds_valid) ds_bus_d = if_id_bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_valid_q <= 1'b0;
            ds_bus_q   <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_bus_q   <= ds_bus_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_we && wb_waddr != 5'd0) begin
            rf_q[wb_waddr] <= wb_wdata;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a table of decoded instructions plus
// directed sequences for bypass, load-use stall, squash, backpressure and reset.
module tb_id_stage;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         fs_to_ds_valid;
    logic [63:0]  if_id_bus_in;
    logic         ds_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [144:0] id_ex_bus_out;
    logic         wb_we;
    logic [4:0]   wb_waddr;
    logic [31:0]  wb_wdata;
    logic         es_load_valid;
    logic [4:0]   es_load_rd;
    logic         br_taken;
    logic [31:0]  br_target;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .fs_to_ds_valid(fs_to_ds_valid),
        .if_id_bus_in(if_id_bus_in), .ds_allowin(ds_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .id_ex_bus_out(id_ex_bus_out),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .es_load_valid(es_load_valid), .es_load_rd(es_load_rd),
        .br_taken(br_taken), .br_target(br_target)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        we;
        logic        br;
        logic [31:0] tgt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(logic [31:0] inst, logic [31:0] pc, logic [31:0] imm,
                                 logic [31:0] r1, logic [31:0] r2, logic we, logic br,
                                 logic [31:0] tgt);
        vec_t v;
        v.inst = inst; v.pc = pc; v.imm = imm; v.r1 = r1; v.r2 = r2;
        v.we = we; v.br = br; v.tgt = tgt;
        return v;
    endfunction

    function automatic logic [144:0] mk(logic we, logic [31:0] inst, logic [31:0] imm,
                                        logic [31:0] r2, logic [31:0] r1, logic [31:0] pc);
        return {we, inst[30], inst[14:12], inst[6:0], inst[11:7], imm, r2, r1, pc};
    endfunction

    task automatic chk(string name, logic [144:0] act, logic [144:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; fs_to_ds_valid = 1'b0; if_id_bus_in = '0; es_allowin = 1'b1;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; es_load_valid = 1'b0; es_load_rd = '0;

        vq.push_back(mkv(32'h00500093, 32'h000, 32'h5,        32'd0,        32'd0,        1, 0, 0));
        vq.push_back(mkv(32'hFFC0A383, 32'h004, 32'hFFFFFFFC, 32'd10,       32'd0,        1, 0, 0));
        vq.push_back(mkv(32'h0020A423, 32'h008, 32'h8,        32'd10,       32'hFFFFFFF0, 0, 0, 0));
        vq.push_back(mkv(32'h123452B7, 32'h00C, 32'h12345000, 32'd0,        32'd0,        1, 0, 0));
        vq.push_back(mkv(32'h00208033, 32'h010, 32'h0,        32'd10,       32'hFFFFFFF0, 0, 0, 0));
        vq.push_back(mkv(32'hFF9FF0EF, 32'h200, 32'hFFFFFFF8, 32'd0,        32'd0,        1, 1, 32'h1F8));
        vq.push_back(mkv(32'h00308067, 32'h204, 32'h3,        32'd10,       32'd0,        0, 1, 32'hC));
        vq.push_back(mkv(32'h00208863, 32'h300, 32'h10,       32'd10,       32'hFFFFFFF0, 0, 0, 0));
        vq.push_back(mkv(32'h00114863, 32'h300, 32'h10,       32'hFFFFFFF0, 32'd10,       0, 1, 32'h310));
        vq.push_back(mkv(32'h00116863, 32'h300, 32'h10,       32'hFFFFFFF0, 32'd10,       0, 0, 0));
        vq.push_back(mkv(32'hFE20DEE3, 32'h400, 32'hFFFFFFFC, 32'd10,       32'hFFFFFFF0, 0, 1, 32'h3FC));
        vq.push_back(mkv(32'h00109863, 32'h404, 32'h10,       32'd10,       32'd10,       0, 0, 0));
        vq.push_back(mkv(32'h00001197, 32'h408, 32'h1000,     32'd0,        32'd0,        1, 0, 0));

        // Reset state, observed before any clock edge.
        #1;
        chk1("rst_vld", ds_to_es_valid, 1'b0);
        chk1("rst_allowin", ds_allowin, 1'b1);
        chk1("rst_br", br_taken, 1'b0);
        chk("rst_bus", id_ex_bus_out, '0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;

        // Preload x1 = 10, x2 = -16.
        @(negedge clk); wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'd10;
        @(negedge clk); wb_waddr = 5'd2; wb_wdata = 32'hFFFFFFF0;
        @(negedge clk); wb_we = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk); fs_to_ds_valid = 1'b1; if_id_bus_in = {vq[i].inst, vq[i].pc};
            @(negedge clk); fs_to_ds_valid = 1'b0; #1;
            chk1($sformatf("vld[%0d]", i), ds_to_es_valid, 1'b1);
            chk($sformatf("bus[%0d]", i), id_ex_bus_out,
                mk(vq[i].we, vq[i].inst, vq[i].imm, vq[i].r2, vq[i].r1, vq[i].pc));
            chk1($sformatf("br[%0d]", i), br_taken, vq[i].br);
            if (vq[i].br) chk($sformatf("tgt[%0d]", i), 145'(br_target), 145'(vq[i].tgt));
        end

        // Writeback bypass into ADD x4,x3,x3.
        @(negedge clk); fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00318233, 32'h800};
        @(negedge clk); fs_to_ds_valid = 1'b0;
        wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hDEADBEEF; #1;
        chk("bypass", id_ex_bus_out, mk(1, 32'h00318233, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h800));
        @(negedge clk); wb_we = 1'b0;

        // Load-use stall on ADD x6,x5,x0 with x5 pending from a load.
        @(negedge clk); es_load_valid = 1'b1; es_load_rd = 5'd5;
        fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00028333, 32'h500};
        @(negedge clk); if_id_bus_in = {32'h00500093, 32'h504}; #1;
        chk1("lu_allowin", ds_allowin, 1'b0);
        chk1("lu_vld", ds_to_es_valid, 1'b0);
        @(negedge clk); es_load_valid = 1'b0; #1;
        chk1("lu_release_vld", ds_to_es_valid, 1'b1);
        chk("lu_release_bus", id_ex_bus_out, mk(1, 32'h00028333, 0, 0, 0, 32'h500));
        @(negedge clk); fs_to_ds_valid = 1'b0; #1;
        chk("lu_next_bus", id_ex_bus_out, mk(1, 32'h00500093, 5, 0, 0, 32'h504));

        // Taken BEQ squashes the instruction fetched in the same cycle.
        @(negedge clk); fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00000863, 32'h100};
        @(negedge clk); if_id_bus_in = {32'h00500093, 32'h104}; #1;
        chk1("beq_taken", br_taken, 1'b1);
        chk("beq_target", 145'(br_target), 145'(32'h110));
        @(negedge clk); fs_to_ds_valid = 1'b0; #1;
        chk1("squash_vld", ds_to_es_valid, 1'b0);

        // Backpressure for three cycles, with a write to x0 during the stall.
        @(negedge clk); es_allowin = 1'b0;
        fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00500093, 32'h600};
        @(negedge clk); if_id_bus_in = {32'h00208033, 32'h604};
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_bus[%0d]", k), id_ex_bus_out, mk(1, 32'h00500093, 5, 0, 0, 32'h600));
            chk1($sformatf("hold_allowin[%0d]", k), ds_allowin, 1'b0);
            chk1($sformatf("hold_vld[%0d]", k), ds_to_es_valid, 1'b1);
            @(negedge clk);
        end
        wb_we = 1'b0; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; #1;
        chk1("hold_release_allowin", ds_allowin, 1'b1);
        @(negedge clk);

        // Reset pulsed while an instruction is stalled.
        es_allowin = 1'b0; fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00208033, 32'h700};
        @(negedge clk); fs_to_ds_valid = 1'b0; #1;
        chk("pre_rst_bus", id_ex_bus_out, mk(0, 32'h00208033, 0, 32'hFFFFFFF0, 32'd10, 32'h700));
        #1; rst_n = 1'b0; #1;
        chk1("midrst_vld", ds_to_es_valid, 1'b0);
        chk1("midrst_allowin", ds_allowin, 1'b1);
        chk1("midrst_br", br_taken, 1'b0);
        @(negedge clk); rst_n = 1'b1; es_allowin = 1'b1;
        @(negedge clk); #1;
        chk1("post_rst_idle_vld", ds_to_es_valid, 1'b0);
        fs_to_ds_valid = 1'b1; if_id_bus_in = {32'h00208033, 32'h700};
        @(negedge clk); fs_to_ds_valid = 1'b0; #1;
        chk1("post_rst_vld", ds_to_es_valid, 1'b1);
        chk("post_rst_regs", id_ex_bus_out, mk(0, 32'h00208033, 0, 0, 0, 32'h700));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
